// File: rtl/sc_reg_shifter_ctrl.sv
// ---------------------------------------------------------------------------
// sc_reg_shifter_ctrl
// Register stage that captures the OR-stage result and shifts it left or
// right one bit per clock under a start/busy/done handshake.
//
// Ports:
//   SC_RegSHIFTER_CLOCK_50     clock, rising edge
//   SC_RegSHIFTER_RESET_InLow  async reset, active low
//   RegSHIFTER_clear_InLow     sync clear of register (aborts a shift), active low
//   RegSHIFTER_load_InLow      sync parallel load, active low (IDLE only)
//   RegSHIFTER_data_In         parallel load data
//   RegSHIFTER_start_In        start a shift operation (IDLE only)
//   RegSHIFTER_dir_In          0 = left (toward MSB), 1 = right (toward LSB)
//   RegSHIFTER_amount_In       number of single-bit shifts
//   RegSHIFTER_serial_In       fill bit for the vacated end
//   RegSHIFTER_data_Out        register contents
//   RegSHIFTER_busy_Out        operation in progress (SHIFT or DONE)
//   RegSHIFTER_done_Out        one-cycle completion pulse
// ---------------------------------------------------------------------------
module sc_reg_shifter_ctrl #(
  parameter int unsigned NUMBER_DATAWIDTH  = 8,
  parameter int unsigned NUMBER_SHAMTWIDTH = 3
) (
  input  logic                         SC_RegSHIFTER_CLOCK_50,
  input  logic                         SC_RegSHIFTER_RESET_InLow,
  input  logic                         RegSHIFTER_clear_InLow,
  input  logic                         RegSHIFTER_load_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0]  RegSHIFTER_data_In,
  input  logic                         RegSHIFTER_start_In,
  input  logic                         RegSHIFTER_dir_In,
  input  logic [NUMBER_SHAMTWIDTH-1:0] RegSHIFTER_amount_In,
  input  logic                         RegSHIFTER_serial_In,
  output logic [NUMBER_DATAWIDTH-1:0]  RegSHIFTER_data_Out,
  output logic                         RegSHIFTER_busy_Out,
  output logic                         RegSHIFTER_done_Out
);

  localparam int unsigned W  = NUMBER_DATAWIDTH;
  localparam int unsigned SW = NUMBER_SHAMTWIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  data_q,  data_d;
  logic [SW-1:0] count_q, count_d;
  logic          dir_q,   dir_d;
  logic          fill_q,  fill_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    dir_d   = dir_q;
    fill_d  = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (!RegSHIFTER_clear_InLow) begin
          data_d = '0;
        end else if (!RegSHIFTER_load_InLow) begin
          data_d = RegSHIFTER_data_In;
        end else if (RegSHIFTER_start_In) begin
          dir_d  = RegSHIFTER_dir_In;
          fill_d = RegSHIFTER_serial_In;
          if (RegSHIFTER_amount_In == '0) begin
            state_d = ST_DONE;
          end else begin
            count_d = RegSHIFTER_amount_In;
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (!RegSHIFTER_clear_InLow) begin
          // Abort: no done pulse
          data_d  = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          data_d  = dir_q ? {fill_q, data_q[W-1:1]} : {data_q[W-2:0], fill_q};
          count_d = count_q - SW'(1);
          if (count_q == SW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!RegSHIFTER_clear_InLow) begin
          data_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // Status flags registered alongside the state they decode
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or negedge SC_RegSHIFTER_RESET_InLow) begin
    if (!SC_RegSHIFTER_RESET_InLow) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RegSHIFTER_data_Out = data_q;
  assign RegSHIFTER_busy_Out = busy_q;
  assign RegSHIFTER_done_Out = done_q;

endmodule
